// File: rtl/budget_sched_pkg.sv
// Shared types and constants for the transaction budget scheduler and its slot ring.
package budget_sched_pkg;

    localparam int LEN_WIDTH = 8;
    localparam int OVERHEAD  = 5;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        TIMEOUT
    } state_t;

    typedef struct packed {
        logic                 occupied;
        logic [LEN_WIDTH-1:0] len;
    } slot_t;

endpackage

// File: rtl/budget_slot_ring.sv
// In-order ring of transaction slots; head is the oldest outstanding entry, tail the next free one.
module budget_slot_ring
    import budget_sched_pkg::*;
#(
    parameter int MaxTxns = 8,
    localparam int IdWidth = $clog2(MaxTxns)
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 flush,
    input  logic                 push,
    input  logic [LEN_WIDTH-1:0] push_len,
    input  logic                 pop,
    output logic [LEN_WIDTH-1:0] head_len,
    output logic [IdWidth-1:0]   tail_id,
    output logic [IdWidth:0]     count,
    output logic                 full,
    output logic                 empty
);

    if (MaxTxns < 2 || (MaxTxns & (MaxTxns - 1)) != 0) begin : g_size_check
        $error("budget_slot_ring: MaxTxns must be a power of two and at least 2");
    end

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [IdWidth:0] head_reg;
    logic [IdWidth:0] tail_reg;
    slot_t            slot_view [MaxTxns];
    slot_t            head_slot;

    always_ff @(posedge clk) begin
        if (srst || flush) begin
            head_reg <= '0;
            tail_reg <= '0;
        end else begin
            if (push) tail_reg <= tail_reg + (IdWidth+1)'(1);
            if (pop)  head_reg <= head_reg + (IdWidth+1)'(1);
        end
    end

    genvar gi;
    for (gi = 0; gi < MaxTxns; gi++) begin : g_slot
        slot_t slot_reg;
        always_ff @(posedge clk) begin
            if (srst || flush) begin
                slot_reg <= '0;
            end else if (push && tail_reg[IdWidth-1:0] == IdWidth'(gi)) begin
                slot_reg <= '{occupied: 1'b1, len: push_len};
            end else if (pop && head_reg[IdWidth-1:0] == IdWidth'(gi)) begin
                slot_reg <= '0;
            end
        end
        assign slot_view[gi] = slot_reg;
    end

    assign head_slot = slot_view[head_reg[IdWidth-1:0]];
    assign head_len  = head_slot.occupied ? head_slot.len : '0;
    assign tail_id   = tail_reg[IdWidth-1:0];
    assign count     = tail_reg - head_reg;
    assign empty     = (tail_reg == head_reg);
    assign full      = (tail_reg[IdWidth-1:0] == head_reg[IdWidth-1:0])
                    && (tail_reg[IdWidth] != head_reg[IdWidth]);

endmodule

// File: rtl/budget_scheduler.sv
// Allocates in-order transaction slots, tracks the summed (len + overhead) budget and raises a
// sticky timeout when the beat-to-beat stall timer reaches that budget.
module budget_scheduler
    import budget_sched_pkg::*;
#(
    parameter int MaxTxns  = 8,
    parameter int LenWidth = 8,
    parameter int Overhead = OVERHEAD,
    parameter int CntWidth = 16,
    localparam int IdWidth = $clog2(MaxTxns)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                alloc_valid_i,
    output logic                alloc_ready_o,
    input  logic [LenWidth-1:0] alloc_len_i,
    output logic [IdWidth-1:0]  alloc_id_o,
    input  logic                beat_i,
    input  logic                retire_i,
    input  logic                timeout_clear_i,
    output logic [CntWidth-1:0] budget_o,
    output logic [CntWidth-1:0] timer_o,
    output logic [IdWidth:0]    outstanding_o,
    output logic                timeout_o,
    output logic                err_o
);

    localparam longint BudgetMax = longint'(MaxTxns) * ((longint'(1) << LenWidth) - 1 + Overhead);

    if ((longint'(1) << CntWidth) <= BudgetMax) begin : g_width_check
        $error("budget_scheduler: CntWidth too narrow for the worst-case budget");
    end
    if (LenWidth != LEN_WIDTH) begin : g_len_check
        $error("budget_scheduler: LenWidth must match the slot length width");
    end

    state_t              state_reg, state_next;
    logic [CntWidth-1:0] budget_reg, budget_next;
    logic [CntWidth-1:0] timer_reg, timer_next;
    logic                err_reg, err_next;

    logic                alloc, retire, flush, open;
    logic                full, empty;
    logic [LenWidth-1:0] head_len;
    logic [CntWidth-1:0] alloc_amt, retire_amt;

    budget_slot_ring #(.MaxTxns(MaxTxns)) u_ring (
        .clk      (clk_i),
        .srst     (rst_i),
        .flush    (flush),
        .push     (alloc),
        .push_len (alloc_len_i),
        .pop      (retire),
        .head_len (head_len),
        .tail_id  (alloc_id_o),
        .count    (outstanding_o),
        .full     (full),
        .empty    (empty)
    );

    assign open          = (state_reg != TIMEOUT);
    assign alloc_ready_o = open && !full;
    assign alloc         = alloc_valid_i && alloc_ready_o;
    assign retire        = retire_i && open && !empty;
    assign flush         = (state_reg == TIMEOUT) && timeout_clear_i;
    assign alloc_amt     = alloc  ? CntWidth'(alloc_len_i) + CntWidth'(Overhead) : '0;
    assign retire_amt    = retire ? CntWidth'(head_len) + CntWidth'(Overhead) : '0;

    always_comb begin
        state_next  = state_reg;
        timer_next  = timer_reg;
        budget_next = budget_reg + alloc_amt - retire_amt;
        err_next    = retire_i && open && empty;
        case (state_reg)
            IDLE: begin
                timer_next = '0;
                if (alloc) state_next = ACTIVE;
            end
            ACTIVE: begin
                // The stall check wins over a same-cycle drain to empty.
                if (timer_reg == budget_reg && !beat_i) begin
                    state_next = TIMEOUT;
                end else if (retire && !alloc && outstanding_o == (IdWidth+1)'(1)) begin
                    state_next = IDLE;
                    timer_next = '0;
                end else if (beat_i || alloc) begin
                    timer_next = '0;
                end else if (timer_reg != {CntWidth{1'b1}}) begin
                    timer_next = timer_reg + CntWidth'(1);
                end
            end
            TIMEOUT: begin
                if (timeout_clear_i) begin
                    state_next  = IDLE;
                    timer_next  = '0;
                    budget_next = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg  <= IDLE;
            budget_reg <= '0;
            timer_reg  <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            budget_reg <= budget_next;
            timer_reg  <= timer_next;
            err_reg    <= err_next;
        end
    end

    assign budget_o  = budget_reg;
    assign timer_o   = timer_reg;
    assign timeout_o = (state_reg == TIMEOUT);
    assign err_o     = err_reg;

endmodule

// File: tb/tb_budget_scheduler.sv
// Directed vector table, a beat-restart sequence and randomized traffic checked against a queue model.
module tb_budget_scheduler;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        alloc_valid_i = 1'b0;
    logic        alloc_ready_o;
    logic [7:0]  alloc_len_i = '0;
    logic [2:0]  alloc_id_o;
    logic        beat_i = 1'b0;
    logic        retire_i = 1'b0;
    logic        timeout_clear_i = 1'b0;
    logic [15:0] budget_o;
    logic [15:0] timer_o;
    logic [3:0]  outstanding_o;
    logic        timeout_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    budget_scheduler dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .alloc_valid_i   (alloc_valid_i),
        .alloc_ready_o   (alloc_ready_o),
        .alloc_len_i     (alloc_len_i),
        .alloc_id_o      (alloc_id_o),
        .beat_i          (beat_i),
        .retire_i        (retire_i),
        .timeout_clear_i (timeout_clear_i),
        .budget_o        (budget_o),
        .timer_o         (timer_o),
        .outstanding_o   (outstanding_o),
        .timeout_o       (timeout_o),
        .err_o           (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit rst, av; int len; bit beat, ret, clr;
        int b, t, o; bit to, err, rdy; int id;
    } vec_t;

    vec_t vecs[$];

    // Behavioural reference: outstanding lengths in issue order plus a few flags.
    int q[$];
    bit m_act, m_to, m_err;
    int m_tmr, m_tail;

    function automatic vec_t v(bit rst, bit av, int len, bit beat, bit ret, bit clr,
                               int b, int t, int o, bit to, bit err, bit rdy, int id);
        vec_t r;
        r.rst = rst; r.av = av; r.len = len; r.beat = beat; r.ret = ret; r.clr = clr;
        r.b = b; r.t = t; r.o = o; r.to = to; r.err = err; r.rdy = rdy; r.id = id;
        return r;
    endfunction

    task automatic drive(bit rst, bit av, int len, bit beat, bit ret, bit clr);
        rst_i = rst; alloc_valid_i = av; alloc_len_i = 8'(len);
        beat_i = beat; retire_i = ret; timeout_clear_i = clr;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_outs(string name, bit verbose, int b, int t, int o, bit to_e, bit err_e,
                              bit rdy_e, int id_e);
        checks++;
        if (budget_o !== 16'(b) || timer_o !== 16'(t) || outstanding_o !== 4'(o) ||
            timeout_o !== to_e || err_o !== err_e || alloc_ready_o !== rdy_e || alloc_id_o !== 3'(id_e)) begin
            errors++;
            $display("FAIL %s: got budget=%0d timer=%0d out=%0d to=%0b err=%0b rdy=%0b id=%0d, expected budget=%0d timer=%0d out=%0d to=%0b err=%0b rdy=%0b id=%0d",
                     name, budget_o, timer_o, outstanding_o, timeout_o, err_o, alloc_ready_o, alloc_id_o,
                     b, t, o, to_e, err_e, rdy_e, id_e);
        end else if (verbose) begin
            $display("ok %s: budget=%0d timer=%0d out=%0d to=%0b err=%0b rdy=%0b id=%0d",
                     name, budget_o, timer_o, outstanding_o, timeout_o, err_o, alloc_ready_o, alloc_id_o);
        end
    endtask

    function automatic int model_budget();
        int s = 0;
        foreach (q[k]) s += q[k] + 5;
        return s;
    endfunction

    task automatic model_step(bit rst, bit av, int len, bit beat, bit ri, bit clr);
        int  n   = q.size();
        int  bud = model_budget();
        bit  a   = av && n < 8 && !m_to;
        bit  r   = ri && n > 0 && !m_to;
        m_err = ri && n == 0 && !m_to;
        if (rst) begin
            q.delete(); m_act = 0; m_to = 0; m_tmr = 0; m_tail = 0; m_err = 0;
            return;
        end
        if (m_to) begin
            if (clr) begin
                q.delete(); m_act = 0; m_to = 0; m_tmr = 0; m_tail = 0;
            end
            return;
        end
        if (!m_act) begin
            m_tmr = 0;
            if (a) m_act = 1;
        end else if (m_tmr == bud && !beat) begin
            m_to = 1;
        end else if (r && !a && n == 1) begin
            m_act = 0; m_tmr = 0;
        end else if (beat || a) begin
            m_tmr = 0;
        end else if (m_tmr < 65535) begin
            m_tmr++;
        end
        if (r) void'(q.pop_front());
        if (a) begin
            q.push_back(len);
            m_tail = (m_tail + 1) % 8;
        end
    endtask

    initial begin
        int exp_t;
        bit bt;

        vecs.push_back(v(0,0,0,0,0,0,   0,0,0,0,0,1,0));
        vecs.push_back(v(0,1,3,0,0,0,   8,0,1,0,0,1,1));
        vecs.push_back(v(0,0,0,0,1,0,   0,0,0,0,0,1,1));
        for (int k = 1; k <= 8; k++)
            vecs.push_back(v(0,1,15,0,0,0, 20*k,0,k,0,0,(k < 8),(1+k)%8));
        vecs.push_back(v(0,1,15,0,1,0,  140,1,7,0,0,1,1));
        vecs.push_back(v(1,0,0,0,0,0,   0,0,0,0,0,1,0));
        vecs.push_back(v(0,1,4,0,0,0,   9,0,1,0,0,1,1));
        vecs.push_back(v(0,1,7,0,0,0,   21,0,2,0,0,1,2));
        vecs.push_back(v(0,1,10,0,1,0,  27,0,2,0,0,1,3));
        vecs.push_back(v(1,0,0,0,0,0,   0,0,0,0,0,1,0));
        vecs.push_back(v(0,1,0,0,0,0,   5,0,1,0,0,1,1));
        for (int k = 1; k <= 5; k++)
            vecs.push_back(v(0,0,0,0,0,0, 5,k,1,0,0,1,1));
        vecs.push_back(v(0,0,0,0,0,0,   5,5,1,1,0,0,1));
        vecs.push_back(v(0,1,9,1,1,0,   5,5,1,1,0,0,1));
        vecs.push_back(v(0,0,0,0,0,1,   0,0,0,0,0,1,0));
        vecs.push_back(v(0,0,0,0,1,0,   0,0,0,0,1,1,0));
        vecs.push_back(v(0,0,0,0,0,0,   0,0,0,0,0,1,0));
        vecs.push_back(v(0,1,2,0,0,0,   7,0,1,0,0,1,1));
        vecs.push_back(v(0,0,0,0,0,1,   7,1,1,0,0,1,1));
        vecs.push_back(v(1,0,0,0,0,0,   0,0,0,0,0,1,0));
        vecs.push_back(v(0,1,1,0,0,0,   6,0,1,0,0,1,1));
        vecs.push_back(v(0,1,2,0,0,0,   13,0,2,0,0,1,2));
        vecs.push_back(v(0,1,3,0,0,0,   21,0,3,0,0,1,3));
        vecs.push_back(v(1,0,0,0,0,0,   0,0,0,0,0,1,0));

        drive(1, 0, 0, 0, 0, 0);
        tick(); tick();

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].av, vecs[i].len, vecs[i].beat, vecs[i].ret, vecs[i].clr);
            tick();
            check_outs($sformatf("vec%0d", i), 1'b1, vecs[i].b, vecs[i].t, vecs[i].o,
                       vecs[i].to, vecs[i].err, vecs[i].rdy, vecs[i].id);
        end

        // Beat every time the stall timer reaches 4 against a budget of 5: never times out.
        drive(0, 1, 0, 0, 0, 0);
        tick();
        check_outs("beat_alloc", 1'b1, 5, 0, 1, 0, 0, 1, 1);
        exp_t = 0;
        for (int c = 0; c < 40; c++) begin
            bt = (exp_t == 4);
            drive(0, 0, 0, bt, 0, 0);
            tick();
            exp_t = bt ? 0 : exp_t + 1;
            check_outs($sformatf("beat_cyc%0d", c), 1'b0, 5, exp_t, 1, 0, 0, 1, 1);
        end
        $display("beat restart: 40 cycles, timeout_o=%0b", timeout_o);

        drive(1, 0, 0, 0, 0, 0);
        tick();
        q.delete(); m_act = 0; m_to = 0; m_err = 0; m_tmr = 0; m_tail = 0;

        for (int c = 0; c < 400; c++) begin
            bit rs, av, bt2, rt, cl;
            int ln;
            rs  = ($urandom_range(0, 99) == 0);
            av  = ($urandom_range(0, 9) < 4);
            ln  = ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, 3));
            bt2 = ($urandom_range(0, 3) == 0);
            rt  = ($urandom_range(0, 3) == 0);
            cl  = ($urandom_range(0, 9) < 3);
            drive(rs, av, ln, bt2, rt, cl);
            model_step(rs, av, ln, bt2, rt, cl);
            tick();
            check_outs($sformatf("rand%0d", c), 1'b0, model_budget(), m_tmr, q.size(), m_to, m_err,
                       (q.size() < 8) && !m_to, m_tail);
        end

        drive(0, 0, 0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
